// File: rtl/hazard_unit_if.sv
// Hazard unit bus: IF/ID and ID/EX fields in, pipeline control and statistics out.
interface hazard_unit_if #(
    parameter int unsigned CNT_W = 16
);
    logic [5:0]       ifIdOpCode;
    logic [4:0]       ifIdRs;
    logic [4:0]       ifIdRt;
    logic             idExMemRead;
    logic [4:0]       idExRt;
    logic             stallSignal;
    logic             pcWrite;
    logic             ifIdWrite;
    logic             ifIdFlush;
    logic [CNT_W-1:0] loadStallCount;
    logic [CNT_W-1:0] branchStallCount;
    logic             busy;

    // Hazard unit side
    modport slave (
        input  ifIdOpCode, ifIdRs, ifIdRt, idExMemRead, idExRt,
        output stallSignal, pcWrite, ifIdWrite, ifIdFlush,
        output loadStallCount, branchStallCount, busy
    );

    // Pipeline side
    modport master (
        output ifIdOpCode, ifIdRs, ifIdRt, idExMemRead, idExRt,
        input  stallSignal, pcWrite, ifIdWrite, ifIdFlush,
        input  loadStallCount, branchStallCount, busy
    );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard sequencer: load-use stalls, fixed beq wait, saturating stall statistics.
module hazard_unit #(
    parameter int unsigned BRANCH_STALL_CYCLES = 2,  // 1..15
    parameter int unsigned CNT_W               = 16
) (
    input  logic          clk,
    input  logic          reset,
    hazard_unit_if.slave  bus
);

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_SW    = 6'd43;

    typedef enum logic [0:0] {
        StIdle,
        StBranchStall
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       remain_q, remain_d;
    logic [CNT_W-1:0] load_cnt_q, load_cnt_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;

    logic uses_rt;
    logic load_hazard;
    logic load_inc;
    logic branch_inc;
    logic stall;
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic busy;

    // Decode which IF/ID source registers are actually read, then detect lw-use
    always_comb begin
        uses_rt = (bus.ifIdOpCode == OP_RTYPE) || (bus.ifIdOpCode == OP_SW) ||
                  (bus.ifIdOpCode == OP_BEQ);
        // $0 never carries a real dependency
        load_hazard = bus.idExMemRead && (bus.idExRt != 5'd0) &&
                      ((bus.idExRt == bus.ifIdRs) || (uses_rt && (bus.idExRt == bus.ifIdRt)));
    end

    // Next-state and pipeline control outputs; reset masks everything to free-running
    always_comb begin
        state_d     = state_q;
        remain_d    = remain_q;
        load_inc    = 1'b0;
        branch_inc  = 1'b0;
        stall       = 1'b0;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        busy        = 1'b0;

        if (!reset) begin
            unique case (state_q)
                StIdle: begin
                    if (load_hazard) begin
                        // Hold PC and IF/ID, bubble into ID/EX; re-check next cycle
                        stall       = 1'b1;
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        load_inc    = 1'b1;
                    end else if (bus.ifIdOpCode == OP_BEQ) begin
                        // beq proceeds to ID/EX; nop goes into IF/ID behind it
                        pc_write    = 1'b0;
                        if_id_flush = 1'b1;
                        branch_inc  = 1'b1;
                        state_d     = StBranchStall;
                        remain_d    = 4'(BRANCH_STALL_CYCLES);
                    end
                end
                StBranchStall: begin
                    stall       = 1'b1;
                    pc_write    = 1'b0;
                    if_id_flush = 1'b1;
                    busy        = 1'b1;
                    branch_inc  = 1'b1;
                    remain_d    = remain_q - 4'd1;
                    // <= 1 also guards against an out-of-range zero count
                    if (remain_q <= 4'd1) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Saturating increments for the statistics counters
    always_comb begin
        load_cnt_d   = load_cnt_q;
        branch_cnt_d = branch_cnt_q;
        if (load_inc && (load_cnt_q != '1)) begin
            load_cnt_d = load_cnt_q + CNT_W'(1);
        end
        if (branch_inc && (branch_cnt_q != '1)) begin
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            remain_q     <= 4'd0;
            load_cnt_q   <= '0;
            branch_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            remain_q     <= remain_d;
            load_cnt_q   <= load_cnt_d;
            branch_cnt_q <= branch_cnt_d;
        end
    end

    // Drive the bus
    always_comb begin
        bus.stallSignal      = stall;
        bus.pcWrite          = pc_write;
        bus.ifIdWrite        = if_id_write;
        bus.ifIdFlush        = if_id_flush;
        bus.busy             = busy;
        bus.loadStallCount   = load_cnt_q;
        bus.branchStallCount = branch_cnt_q;
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: a 16-bit-counter instance and a 2-bit-counter instance
// share stimulus; the narrow one saturates early and has its own reset.
module tb_hazard_unit;

    // {stallSignal, pcWrite, ifIdWrite, ifIdFlush, busy}
    localparam logic [4:0] CTL_IDLE  = 5'b01100;
    localparam logic [4:0] CTL_LOAD  = 5'b10000;
    localparam logic [4:0] CTL_ENTRY = 5'b00110;
    localparam logic [4:0] CTL_BWAIT = 5'b10111;

    logic       clk = 1'b0;
    logic       rst16 = 1'b1;
    logic       rst2 = 1'b1;
    logic [5:0] op = '0;
    logic [4:0] rs = '0;
    logic [4:0] rt = '0;
    logic       mem_read = 1'b0;
    logic [4:0] ex_rt = '0;

    int vectors = 0;
    int miscompares = 0;

    hazard_unit_if #(.CNT_W(16)) b16 ();
    hazard_unit_if #(.CNT_W(2))  b2 ();

    assign b16.ifIdOpCode  = op;
    assign b16.ifIdRs      = rs;
    assign b16.ifIdRt      = rt;
    assign b16.idExMemRead = mem_read;
    assign b16.idExRt      = ex_rt;
    assign b2.ifIdOpCode   = op;
    assign b2.ifIdRs       = rs;
    assign b2.ifIdRt       = rt;
    assign b2.idExMemRead  = mem_read;
    assign b2.idExRt       = ex_rt;

    hazard_unit #(.BRANCH_STALL_CYCLES(2), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (rst16),
        .bus   (b16.slave)
    );

    hazard_unit #(.BRANCH_STALL_CYCLES(2), .CNT_W(2)) dut_sat (
        .clk   (clk),
        .reset (rst2),
        .bus   (b2.slave)
    );

    logic [4:0] ctl16;
    logic [4:0] ctl2;
    assign ctl16 = {b16.stallSignal, b16.pcWrite, b16.ifIdWrite, b16.ifIdFlush, b16.busy};
    assign ctl2  = {b2.stallSignal, b2.pcWrite, b2.ifIdWrite, b2.ifIdFlush, b2.busy};

    always #5 clk = ~clk;

    // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst16 = 1'b1;
        rst2 = 1'b1;
        // A live hazard on the inputs must be masked while reset is high
        mem_read = 1'b1; ex_rt = 5'd8; op = 6'd35; rs = 5'd8;
        #1;
        vectors++;
        if (ctl16 !== CTL_IDLE) begin
            miscompares++;
            $display("FAIL reset_mask: ctl=%b expected %b", ctl16, CTL_IDLE);
        end
        tick();
        tick();
        rst16 = 1'b0;
        rst2 = 1'b0;
        mem_read = 1'b0; ex_rt = 5'd0; op = 6'd0; rs = 5'd0; rt = 5'd0;
        for (int i = 0; i < 5; i++) begin
            #1;
            vectors++;
            if (ctl16 !== CTL_IDLE) begin
                miscompares++;
                $display("FAIL idle_cycle%0d: ctl=%b expected %b", i, ctl16, CTL_IDLE);
            end
            tick();
        end
        vectors++;
        if (b16.loadStallCount !== 16'd0 || b16.branchStallCount !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_counters: load=%0d branch=%0d expected 0 0",
                     b16.loadStallCount, b16.branchStallCount);
        end
    endtask

    task automatic test_load_rs();
        mem_read = 1'b1; ex_rt = 5'd8; op = 6'd35; rs = 5'd8; rt = 5'd0;
        #1;
        vectors++;
        if (ctl16 !== CTL_LOAD) begin
            miscompares++;
            $display("FAIL load_rs_stall: ctl=%b expected %b", ctl16, CTL_LOAD);
        end
        tick();
        mem_read = 1'b0;
        #1;
        vectors++;
        if (ctl16 !== CTL_IDLE) begin
            miscompares++;
            $display("FAIL load_rs_release: ctl=%b expected %b", ctl16, CTL_IDLE);
        end
        vectors++;
        if (b16.loadStallCount !== 16'd1) begin
            miscompares++;
            $display("FAIL load_rs_count: got %0d expected 1", b16.loadStallCount);
        end
        tick();
    endtask

    task automatic test_rt_filter();
        // lw reads only rs, so a matching rt is not a dependency
        mem_read = 1'b1; ex_rt = 5'd9; rt = 5'd9; rs = 5'd3; op = 6'd35;
        #1;
        vectors++;
        if (ctl16 !== CTL_IDLE) begin
            miscompares++;
            $display("FAIL rt_lw_nostall: ctl=%b expected %b", ctl16, CTL_IDLE);
        end
        tick();
        op = 6'd43;
        #1;
        vectors++;
        if (ctl16 !== CTL_LOAD) begin
            miscompares++;
            $display("FAIL rt_sw_stall: ctl=%b expected %b", ctl16, CTL_LOAD);
        end
        tick();
        ex_rt = 5'd0; rs = 5'd0; rt = 5'd0; op = 6'd0;
        #1;
        vectors++;
        if (ctl16 !== CTL_IDLE) begin
            miscompares++;
            $display("FAIL zero_reg_nostall: ctl=%b expected %b", ctl16, CTL_IDLE);
        end
        tick();
        mem_read = 1'b0;
        vectors++;
        if (b16.loadStallCount !== 16'd2) begin
            miscompares++;
            $display("FAIL rt_filter_count: got %0d expected 2", b16.loadStallCount);
        end
    endtask

    task automatic test_beq();
        mem_read = 1'b0; op = 6'd4; rs = 5'd1; rt = 5'd2;
        #1;
        vectors++;
        if (ctl16 !== CTL_ENTRY) begin
            miscompares++;
            $display("FAIL beq_entry: ctl=%b expected %b", ctl16, CTL_ENTRY);
        end
        tick();
        op = 6'd0;
        for (int i = 1; i <= 2; i++) begin
            #1;
            vectors++;
            if (ctl16 !== CTL_BWAIT) begin
                miscompares++;
                $display("FAIL beq_wait%0d: ctl=%b expected %b", i, ctl16, CTL_BWAIT);
            end
            tick();
        end
        #1;
        vectors++;
        if (ctl16 !== CTL_IDLE) begin
            miscompares++;
            $display("FAIL beq_resume: ctl=%b expected %b", ctl16, CTL_IDLE);
        end
        vectors++;
        if (b16.branchStallCount !== 16'd3) begin
            miscompares++;
            $display("FAIL beq_count: got %0d expected 3", b16.branchStallCount);
        end
        tick();
    endtask

    task automatic test_beq_after_lw();
        rst16 = 1'b1;
        tick();
        rst16 = 1'b0;
        mem_read = 1'b1; ex_rt = 5'd5; op = 6'd4; rs = 5'd0; rt = 5'd5;
        #1;
        vectors++;
        if (ctl16 !== CTL_LOAD) begin
            miscompares++;
            $display("FAIL beqlw_load: ctl=%b expected %b", ctl16, CTL_LOAD);
        end
        tick();
        mem_read = 1'b0;
        #1;
        vectors++;
        if (ctl16 !== CTL_ENTRY) begin
            miscompares++;
            $display("FAIL beqlw_entry: ctl=%b expected %b", ctl16, CTL_ENTRY);
        end
        tick();
        op = 6'd0;
        for (int i = 1; i <= 2; i++) begin
            #1;
            vectors++;
            if (ctl16 !== CTL_BWAIT) begin
                miscompares++;
                $display("FAIL beqlw_wait%0d: ctl=%b expected %b", i, ctl16, CTL_BWAIT);
            end
            tick();
        end
        #1;
        vectors++;
        if (ctl16 !== CTL_IDLE || b16.loadStallCount !== 16'd1 ||
            b16.branchStallCount !== 16'd3) begin
            miscompares++;
            $display("FAIL beqlw_end: ctl=%b load=%0d branch=%0d expected %b 1 3",
                     ctl16, b16.loadStallCount, b16.branchStallCount, CTL_IDLE);
        end
        tick();
    endtask

    task automatic test_saturation();
        // Narrow instance has seen 3 load stalls and 6 branch stall cycles by now
        vectors++;
        if (b2.loadStallCount !== 2'd3 || b2.branchStallCount !== 2'd3) begin
            miscompares++;
            $display("FAIL sat_pre: load=%0d branch=%0d expected 3 3",
                     b2.loadStallCount, b2.branchStallCount);
        end
        mem_read = 1'b1; ex_rt = 5'd7; op = 6'd0; rs = 5'd7; rt = 5'd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (ctl2 !== CTL_LOAD) begin
                miscompares++;
                $display("FAIL sat_stall%0d: ctl=%b expected %b", i, ctl2, CTL_LOAD);
            end
            tick();
        end
        mem_read = 1'b0;
        #1;
        vectors++;
        if (b2.loadStallCount !== 2'd3 || b16.loadStallCount !== 16'd4) begin
            miscompares++;
            $display("FAIL sat_hold: narrow=%0d wide=%0d expected 3 4",
                     b2.loadStallCount, b16.loadStallCount);
        end
        tick();
    endtask

    task automatic test_reset_in_branch();
        mem_read = 1'b0; op = 6'd4;
        tick();
        op = 6'd0;
        #1;
        vectors++;
        if (ctl2 !== CTL_BWAIT) begin
            miscompares++;
            $display("FAIL rstbr_inwait: ctl=%b expected %b", ctl2, CTL_BWAIT);
        end
        rst16 = 1'b1;
        rst2 = 1'b1;
        #1;
        vectors++;
        if (ctl2 !== CTL_IDLE || ctl16 !== CTL_IDLE) begin
            miscompares++;
            $display("FAIL rstbr_same_cycle: narrow=%b wide=%b expected %b",
                     ctl2, ctl16, CTL_IDLE);
        end
        tick();
        rst16 = 1'b0;
        rst2 = 1'b0;
        #1;
        vectors++;
        if (ctl2 !== CTL_IDLE || b2.loadStallCount !== 2'd0 || b2.branchStallCount !== 2'd0) begin
            miscompares++;
            $display("FAIL rstbr_after: ctl=%b load=%0d branch=%0d expected %b 0 0",
                     ctl2, b2.loadStallCount, b2.branchStallCount, CTL_IDLE);
        end
        tick();
        vectors++;
        if (ctl16 !== CTL_IDLE || b16.branchStallCount !== 16'd0) begin
            miscompares++;
            $display("FAIL rstbr_no_residue: ctl=%b branch=%0d expected %b 0",
                     ctl16, b16.branchStallCount, CTL_IDLE);
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_load_rs();
        test_rt_filter();
        test_beq();
        test_beq_after_lw();
        test_saturation();
        test_reset_in_branch();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard time limit so the bench always ends
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard sequencer for the 5-stage MIPS core. Inspects IF/ID and ID/EX and produces the `stallSignal` consumed by controlUnit, which forces a nop bubble.
- Also produces PC and IF/ID write/flush enables.
- Handles load-use stalls (1 cycle) and beq control stalls (fixed wait until the branch resolves in MEM).
- Keeps saturating stall-cycle counters for performance debug.

Parameters:
- BRANCH_STALL_CYCLES, 2: cycles held in BRANCH_STALL after the beq entry cycle; range 1..15.
- CNT_W, 16: width of the stall statistics counters.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- ifIdOpCode  input  6  opcode of the instruction in IF/ID.
- ifIdRs  input  5  rs field of IF/ID.
- ifIdRt  input  5  rt field of IF/ID.
- idExMemRead  input  1  memRead of the instruction in ID/EX (lw).
- idExRt  input  5  destination rt of the instruction in ID/EX.
- stallSignal  output  1  to controlUnit; 1 = zero all control signals (bubble).
- pcWrite  output  1  1 = PC may update.
- ifIdWrite  output  1  1 = IF/ID may load.
- ifIdFlush  output  1  1 = IF/ID loads nop (0x00000000) instead of the fetched word.
- loadStallCount  output  CNT_W  total load-use stall cycles, saturating.
- branchStallCount  output  CNT_W  total branch stall cycles, saturating.
- busy  output  1  1 while the FSM is in BRANCH_STALL.

Behaviour:
- FSM states: IDLE, BRANCH_STALL. A down-counter `remain` holds 4 bits.
- usesRt = ifIdOpCode is 0 (R-type), 43 (sw) or 4 (beq). lw (35) and all other opcodes use rs only.
- loadHazard = idExMemRead && idExRt != 0 && (idExRt == ifIdRs || (usesRt && idExRt == ifIdRt)). Combinational, same cycle.
- IDLE, loadHazard = 1:
  - stallSignal = 1, pcWrite = 0, ifIdWrite = 0, ifIdFlush = 0.
  - State stays IDLE; the IF/ID instruction is re-evaluated next cycle.
  - loadStallCount increments.
- IDLE, no hazard, ifIdOpCode == 4 (branch entry cycle):
  - stallSignal = 0, so beq advances to ID/EX.
  - pcWrite = 0, ifIdWrite = 1, ifIdFlush = 1, so IF/ID becomes nop and PC holds.
  - Next state is BRANCH_STALL with remain = BRANCH_STALL_CYCLES.
  - branchStallCount increments.
- IDLE, otherwise: stallSignal = 0, pcWrite = 1, ifIdWrite = 1, ifIdFlush = 0.
- BRANCH_STALL:
  - stallSignal = 1, pcWrite = 0, ifIdWrite = 1, ifIdFlush = 1, busy = 1.
  - branchStallCount increments.
  - remain decrements each cycle; when remain == 1, next state is IDLE.
  - Total PC-frozen cycles per beq = 1 + BRANCH_STALL_CYCLES.
  - IF/ID inputs are ignored; loadHazard is not evaluated or counted in this state.
- Priority: loadHazard over beq entry. A beq that depends on a lw first takes 1 load stall, then its branch entry cycle on the next cycle.
- Counters saturate at all-ones and do not wrap.
- Reset (synchronous):
  - While reset = 1 at an edge: state -> IDLE, remain -> 0, both counters -> 0.
  - Outputs in any cycle where reset = 1: stallSignal = 0, pcWrite = 1, ifIdWrite = 1, ifIdFlush = 0, busy = 0; hazards are masked.
  - Reset during BRANCH_STALL aborts the wait immediately; no partial state survives.
- Outputs are purely a function of the current state, the current inputs and reset. No extra latency.

Test Plan:
- Reset, then idExMemRead = 0, ifIdOpCode = 0 for 5 cycles -> pcWrite = 1, ifIdWrite = 1, stallSignal = 0, ifIdFlush = 0; both counters = 0.
- Load-use on rs:
  - Stimulus: idExMemRead = 1, idExRt = 8, ifIdOpCode = 35, ifIdRs = 8 for 1 cycle, then idExMemRead = 0.
  - Response: exactly 1 cycle of stallSignal = 1, pcWrite = 0, ifIdWrite = 0; loadStallCount = 1.
- rt and $0 filtering:
  - idExRt = 9, ifIdRt = 9, ifIdOpCode = 35 -> no stall.
  - Same with ifIdOpCode = 43 -> stall.
  - idExRt = 0 with ifIdRs = 0 -> no stall.
- beq, default BRANCH_STALL_CYCLES = 2:
  - Stimulus: ifIdOpCode = 4 with no hazard.
  - Cycle 0: stallSignal = 0, pcWrite = 0, ifIdFlush = 1.
  - Cycles 1-2: stallSignal = 1, pcWrite = 0, ifIdFlush = 1, busy = 1.
  - Cycle 3: IDLE, pcWrite = 1.
  - branchStallCount = 3.
- beq dependent on lw (idExMemRead = 1, idExRt = 5, ifIdOpCode = 4, ifIdRt = 5):
  - Cycle 0 is a load stall (ifIdWrite = 0).
  - Cycle 1 is the branch entry, followed by 2 BRANCH_STALL cycles.
  - Counters end at load = 1, branch = 3.
- Reset asserted in the first BRANCH_STALL cycle, with CNT_W = 2 pre-saturated:
  - Outputs go idle in that cycle.
  - State is IDLE and counters are 0 after the edge.
  - Separately, with no reset, driving more than 3 stall cycles holds the counter at 3 (saturation).
